// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control sequencer for the 32-bit CPU datapath.
// Owns PC and IR and steps each instruction through
// FETCH -> DECODE -> EXEC -> MEM -> WB. All outputs are Moore outputs
// decoded from the state and IR, so an asynchronous reset clears them
// (including the memory requests) without waiting for a clock edge.
module alu_seq_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [5:0]        alu_op,
    output logic              alu_bsel,
    output logic [DATA_W-1:0] imm_ext,
    input  logic              alu_zero,
    output logic [4:0]        rf_ra1,
    output logic [4:0]        rf_ra2,
    output logic [4:0]        rf_wa,
    output logic              rf_we,
    output logic              rf_wsel,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_ack,
    output logic              busy,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [5:0] OP_NOOP = 6'b000000;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b100000;
    localparam logic [5:0] OP_LWI  = 6'b111011;
    localparam logic [5:0] OP_SWI  = 6'b111100;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_br;

    // Immediate-operand ALU ops (B operand taken from imm_ext).
    function automatic logic is_imm(input logic [5:0] op);
        return ((op >= 6'b110010) && (op <= 6'b110101)) || (op == 6'b111001);
    endfunction

    // Ops that finish with an ALU result written back.
    function automatic logic is_alu(input logic [5:0] op);
        return (op == 6'b010000) || ((op >= 6'b010010) && (op <= 6'b010101)) || is_imm(op);
    endfunction

    // Anything not listed here raises illegal and behaves as NOOP.
    function automatic logic is_defined(input logic [5:0] op);
        return (op == OP_NOOP) || (op == OP_HALT) || is_alu(op) ||
               (op == OP_BEQ) || (op == OP_LWI) || (op == OP_SWI);
    endfunction

    assign opcode    = ir_q[31:26];
    assign imm_ext   = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign rf_ra1    = ir_q[20:16];
    assign rf_ra2    = ir_q[15:11];
    assign rf_wa     = ir_q[25:21];
    assign dmem_addr = ir_q[ADDR_W-1:0];
    assign pc        = pc_q;
    // PC arithmetic is naturally modulo 2^ADDR_W; negative offsets wrap.
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign pc_br     = pc_q + ADDR_W'(1) + imm_ext[ADDR_W-1:0];

    // State, PC and instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RST_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        imem_req = 1'b0;
        alu_op   = 6'b000000;
        alu_bsel = 1'b0;
        rf_we    = 1'b0;
        rf_wsel  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        busy     = 1'b1;
        illegal  = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_op   = opcode;
                alu_bsel = is_imm(opcode);
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (opcode == OP_NOOP || !is_defined(opcode)) begin
                    illegal = !is_defined(opcode);
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op   = opcode;
                alu_bsel = is_imm(opcode);
                if (is_alu(opcode)) begin
                    state_d = S_WB;
                end else if (opcode == OP_BEQ) begin
                    pc_d    = alu_zero ? pc_br : pc_inc;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                alu_op   = opcode;
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_SWI);
                if (dmem_ack) begin
                    if (opcode == OP_SWI) begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                alu_op   = opcode;
                alu_bsel = is_imm(opcode);
                rf_we    = 1'b1;
                rf_wsel  = (opcode == OP_LWI);
                pc_d     = pc_inc;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                busy = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: steps the sequencer cycle by cycle,
// playing the instruction and data memories by hand.
module tb_alu_seq_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              imem_req;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic [ADDR_W-1:0] pc;
    logic [5:0]        alu_op;
    logic              alu_bsel;
    logic [DATA_W-1:0] imm_ext;
    logic              alu_zero;
    logic [4:0]        rf_ra1;
    logic [4:0]        rf_ra2;
    logic [4:0]        rf_wa;
    logic              rf_we;
    logic              rf_wsel;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_ack;
    logic              busy;
    logic              illegal;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0    = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(0), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .alu_op(alu_op), .alu_bsel(alu_bsel), .imm_ext(imm_ext),
        .alu_zero(alu_zero), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_ack(dmem_ack), .busy(busy), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Called in FETCH; holds ack low for 'waits' cycles, then returns the
    // word. Leaves the DUT in DECODE.
    task automatic do_fetch(input logic [31:0] instr, input int waits);
        for (int i = 0; i < waits; i++) begin
            chk("fetch_wait_req", 64'(imem_req), 64'(1));
            step();
        end
        chk("fetch_req", 64'(imem_req), 64'(1));
        imem_rdata = instr;
        imem_ack   = 1'b1;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic noop();
        do_fetch(32'h0, 0);
        step();
    endtask

    // Reset, release, pulse start: leaves the DUT in FETCH at pc 0.
    task automatic reset_start();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        alu_zero = 1'b0; dmem_ack = 1'b0;
        step();
        step();
        chk("rst_pc", 64'(pc), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_imem_req", 64'(imem_req), 64'(0));
        chk("rst_alu_op", 64'(alu_op), 64'(0));
        chk("rst_rf_wa", 64'(rf_wa), 64'(0));
        rst_n = 1'b1;
        step();
        chk("idle_busy", 64'(busy), 64'(0));
        start = 1'b1;
        step();
        start = 1'b0;

        // ADD r3 = r1 + r2
        chk("add_fetch_aluop", 64'(alu_op), 64'(0));
        chk("add_fetch_busy", 64'(busy), 64'(1));
        do_fetch(mk(6'b010010, 5'd3, 5'd1, 16'h1000), 0);
        chk("add_dec_aluop", 64'(alu_op), 64'h12);
        chk("add_dec_ireq", 64'(imem_req), 64'(0));
        chk("add_dec_we", 64'(rf_we), 64'(0));
        step();
        chk("add_exec_aluop", 64'(alu_op), 64'h12);
        chk("add_exec_we", 64'(rf_we), 64'(0));
        step();
        chk("add_wb_we", 64'(rf_we), 64'(1));
        chk("add_wb_wa", 64'(rf_wa), 64'(3));
        chk("add_wb_ra1", 64'(rf_ra1), 64'(1));
        chk("add_wb_ra2", 64'(rf_ra2), 64'(2));
        chk("add_wb_bsel", 64'(alu_bsel), 64'(0));
        chk("add_wb_wsel", 64'(rf_wsel), 64'(0));
        step();
        chk("add_pc", 64'(pc), 64'(1));
        chk("add_after_we", 64'(rf_we), 64'(0));

        // Walk to pc 5, then BEQ -2 taken and not taken
        for (int i = 0; i < 4; i++) noop();
        chk("noop_pc5", 64'(pc), 64'(5));
        do_fetch(mk(6'b100000, 5'd0, 5'd0, 16'hFFFE), 0);
        chk("beq1_dec_we", 64'(rf_we), 64'(0));
        step();
        alu_zero = 1'b1;
        chk("beq1_exec_we", 64'(rf_we), 64'(0));
        step();
        alu_zero = 1'b0;
        chk("beq_taken_pc", 64'(pc), 64'(4));
        noop();
        chk("noop_back_pc5", 64'(pc), 64'(5));
        do_fetch(mk(6'b100000, 5'd0, 5'd0, 16'hFFFE), 0);
        chk("beq2_dec_we", 64'(rf_we), 64'(0));
        step();
        chk("beq2_exec_we", 64'(rf_we), 64'(0));
        step();
        chk("beq_not_taken_pc", 64'(pc), 64'(6));

        // LWI r7 <- mem[0x42] with slow memories: 10 cycles total
        c0 = cyc;
        do_fetch(mk(6'b111011, 5'd7, 5'd0, 16'h0042), 3);
        chk("lwi_dec_aluop", 64'(alu_op), 64'h3B);
        step();
        step();
        chk("lwi_mem_req", 64'(dmem_req), 64'(1));
        chk("lwi_mem_we", 64'(dmem_we), 64'(0));
        chk("lwi_mem_addr", 64'(dmem_addr), 64'h42);
        step();
        chk("lwi_mem_wait1", 64'(dmem_req), 64'(1));
        step();
        chk("lwi_mem_wait2", 64'(dmem_req), 64'(1));
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("lwi_wb_we", 64'(rf_we), 64'(1));
        chk("lwi_wb_wsel", 64'(rf_wsel), 64'(1));
        chk("lwi_wb_wa", 64'(rf_wa), 64'(7));
        chk("lwi_wb_dreq", 64'(dmem_req), 64'(0));
        chk("lwi_cycles", 64'(cyc - c0 + 1), 64'(10));
        step();
        chk("lwi_pc", 64'(pc), 64'(7));

        // Undefined opcode 000111
        do_fetch(mk(6'b000111, 5'd0, 5'd0, 16'h0000), 0);
        chk("ill_dec_pulse", 64'(illegal), 64'(1));
        step();
        chk("ill_after", 64'(illegal), 64'(0));
        chk("ill_pc", 64'(pc), 64'(8));
        chk("ill_next_fetch", 64'(imem_req), 64'(1));

        // ADDI r5 with negative immediate
        do_fetch(mk(6'b110010, 5'd5, 5'd4, 16'h8001), 0);
        chk("addi_dec_bsel", 64'(alu_bsel), 64'(1));
        chk("addi_imm_ext", 64'(imm_ext), 64'hFFFF8001);
        step();
        chk("addi_exec_bsel", 64'(alu_bsel), 64'(1));
        step();
        chk("addi_wb_we", 64'(rf_we), 64'(1));
        chk("addi_wb_wa", 64'(rf_wa), 64'(5));
        step();
        chk("addi_pc", 64'(pc), 64'(9));

        // SWI aborted by asynchronous reset while in MEM
        do_fetch(mk(6'b111100, 5'd0, 5'd2, 16'h0010), 0);
        step();
        step();
        chk("swi_mem_req", 64'(dmem_req), 64'(1));
        chk("swi_mem_we", 64'(dmem_we), 64'(1));
        chk("swi_mem_addr", 64'(dmem_addr), 64'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_dreq_drop", 64'(dmem_req), 64'(0));
        chk("async_dwe_drop", 64'(dmem_we), 64'(0));
        chk("async_pc", 64'(pc), 64'(0));
        chk("async_busy", 64'(busy), 64'(0));
        step();
        chk("async_no_we", 64'(rf_we), 64'(0));
        rst_n = 1'b1;
        step();
        step();
        chk("idle_wait_busy", 64'(busy), 64'(0));
        chk("idle_wait_ireq", 64'(imem_req), 64'(0));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_fetch", 64'(imem_req), 64'(1));

        // BEQ -3 from pc 0 wraps to 0xFE; NOOP to 0xFF; HALT
        do_fetch(mk(6'b100000, 5'd0, 5'd0, 16'hFFFD), 0);
        step();
        alu_zero = 1'b1;
        step();
        alu_zero = 1'b0;
        chk("wrap_beq_pc", 64'(pc), 64'hFE);
        noop();
        chk("noop_pc_ff", 64'(pc), 64'hFF);
        do_fetch(32'hFC00_0000, 0);
        step();
        chk("halt_busy", 64'(busy), 64'(0));
        chk("halt_pc", 64'(pc), 64'hFF);
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        chk("halt_start_busy", 64'(busy), 64'(0));
        chk("halt_start_ireq", 64'(imem_req), 64'(0));
        chk("halt_start_pc", 64'(pc), 64'hFF);
        chk("halt_aluop", 64'(alu_op), 64'(0));

        // BEQ -2 from pc 0 gives 0xFF; NOOP there wraps to 0
        reset_start();
        do_fetch(mk(6'b100000, 5'd0, 5'd0, 16'hFFFE), 0);
        step();
        alu_zero = 1'b1;
        step();
        alu_zero = 1'b0;
        chk("wrap_beq_ff", 64'(pc), 64'hFF);
        noop();
        chk("noop_wrap_pc", 64'(pc), 64'h00);
        chk("noop_wrap_busy", 64'(busy), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
